micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 170 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks a combinational microcode ROM and issues one registered control word per cycle.
// Optional 4-deep call/return stack when MSEQ_CALL_STACK_EN is defined; err stays 0 without it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start, no ops issued
// S_RUN  | consuming one ROM word per non-stalled cycle
// S_HALT | one-cycle done pulse after a HALT word, then back to idle
// S_ERR  | stack overflow/underflow; pc frozen until start or reset
module micro_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_addr,
  output logic [15:0] reg_out,
  input  logic [1:0]  condition,
  input  logic        BT,
  input  logic [5:0]  OPs,
  input  logic [15:0] jump_addr,
  input  logic        z_flag,
  input  logic        cores_done,
  input  logic        dp_stall,
  output logic [5:0]  ops_out,
  output logic        ops_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_ERR} state_t;

  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t      state;
  state_t      state_nxt;
  logic        cond_sel;
  logic        take_branch;
  logic        consume;
  logic        is_halt;
  logic        load_ops;
  logic        do_pop;
  logic        stack_err;
  logic [15:0] pc_inc;
  logic [15:0] pc_nxt;
  logic [15:0] ret_addr;

  always_comb begin
    cond_sel = 1'b0;
    unique case (condition)
      2'b00: cond_sel = 1'b1;
      2'b01: cond_sel = z_flag;
      2'b10: cond_sel = ~z_flag;
      2'b11: cond_sel = cores_done;
      default: cond_sel = 1'b0;
    endcase
  end

  assign take_branch = BT & cond_sel;
  assign pc_inc      = reg_out + 16'd1;
  assign consume     = (state == S_RUN) & ~dp_stall;
  assign is_halt     = (OPs == OP_HALT);
  assign load_ops    = consume & ~is_halt & ~stack_err;

`ifdef MSEQ_CALL_STACK_EN
  localparam logic [5:0] OP_CALL = 6'h3E;
  localparam logic [5:0] OP_RET  = 6'h3D;

  logic [2:0]  sp;
  logic [2:0]  sp_dec;
  logic [15:0] stack_mem [4];
  logic        do_push;

  // A CALL whose condition fails is just an increment and never touches the stack.
  assign do_push   = consume & BT & (OPs == OP_CALL) & cond_sel;
  assign do_pop    = consume & ~BT & (OPs == OP_RET);
  assign stack_err = (do_push & (sp == 3'd4)) | (do_pop & (sp == 3'd0));
  assign sp_dec    = sp - 3'd1;
  assign ret_addr  = stack_mem[sp_dec[1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= 3'd0;
    end else if (do_push && !stack_err) begin
      sp <= sp + 3'd1;
    end else if (do_pop && !stack_err) begin
      sp <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !stack_err) begin
      stack_mem[sp[1:0]] <= pc_inc;
    end
  end
`else
  assign do_pop    = 1'b0;
  assign stack_err = 1'b0;
  assign ret_addr  = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (consume && is_halt) begin
          state_nxt = S_HALT;
        end else if (stack_err) begin
          state_nxt = S_ERR;
        end
      end
      S_HALT:  state_nxt = S_IDLE;
      S_ERR:   if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_HALT);
`ifdef MSEQ_CALL_STACK_EN
    err  = (state == S_ERR);
`else
    err  = 1'b0;
`endif
  end

  always_comb begin
    pc_nxt = reg_out;
    unique case (state)
      S_IDLE, S_ERR: if (start) pc_nxt = start_addr;
      S_RUN: begin
        if (load_ops) begin
          if (do_pop) begin
            pc_nxt = ret_addr;
          end else if (take_branch) begin
            pc_nxt = jump_addr;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: pc_nxt = reg_out;
    endcase
  end

  // ops_out keeps its last value whenever no word is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_out   <= 16'h0000;
      ops_out   <= 6'h00;
      ops_valid <= 1'b0;
    end else begin
      reg_out   <= pc_nxt;
      ops_valid <= load_ops;
      if (load_ops) begin
        ops_out <= OPs;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; ROM is a table indexed by reg_out[5:0].
// Expectations follow MSEQ_CALL_STACK_EN when the bench is built with it.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] reg_out;
  logic [1:0]  condition;
  logic        BT;
  logic [5:0]  OPs;
  logic [15:0] jump_addr;
  logic        z_flag;
  logic        cores_done;
  logic        dp_stall;
  logic [5:0]  ops_out;
  logic        ops_valid;
  logic        busy;
  logic        done;
  logic        err;

  logic        rom_bt   [64];
  logic [1:0]  rom_cond [64];
  logic [5:0]  rom_ops  [64];
  logic [15:0] rom_jmp  [64];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign BT        = rom_bt[reg_out[5:0]];
  assign condition = rom_cond[reg_out[5:0]];
  assign OPs       = rom_ops[reg_out[5:0]];
  assign jump_addr = rom_jmp[reg_out[5:0]];

  micro_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .reg_out    (reg_out),
    .condition  (condition),
    .BT         (BT),
    .OPs        (OPs),
    .jump_addr  (jump_addr),
    .z_flag     (z_flag),
    .cores_done (cores_done),
    .dp_stall   (dp_stall),
    .ops_out    (ops_out),
    .ops_valid  (ops_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // default word: BT=0, a harmless op equal to the low address nibble
  task automatic rom_clear();
    for (int i = 0; i < 64; i++) begin
      rom_bt[i]   = 1'b0;
      rom_cond[i] = 2'b00;
      rom_ops[i]  = 6'(i % 16);
      rom_jmp[i]  = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [15:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = 16'h0; z_flag = 1'b0;
    cores_done = 1'b0; dp_stall = 1'b0;
    rom_clear();
    tick(); tick();
    check_val("rst_pc", 32'(reg_out), 32'd0);
    check_val("rst_ops", 32'(ops_out), 32'd0);
    check_val("rst_flags", {28'd0, ops_valid, busy, done, err}, 32'd0);
    rst_n = 1'b1;

    // straight-line run from 5
    launch(16'd5);
    check_val("run_pc5", 32'(reg_out), 32'd5);
    check_val("run_busy", 32'(busy), 32'd1);
    check_val("run_v0", 32'(ops_valid), 32'd0);
    tick();
    check_val("run_pc6", 32'(reg_out), 32'd6);
    check_val("run_v1", {26'd0, ops_valid, ops_out}, {26'd0, 1'b1, 6'd5});
    tick();
    check_val("run_pc7", 32'(reg_out), 32'd7);

    // cond 10 taken when z_flag=0
    rom_bt[6] = 1'b1; rom_cond[6] = 2'b10; rom_jmp[6] = 16'd20;
    do_reset();
    launch(16'd5); tick(); tick();
    check_val("br_nz_taken", 32'(reg_out), 32'd20);
    check_val("br_nz_ops", {26'd0, ops_valid, ops_out}, {26'd0, 1'b1, 6'd6});
    tick();
    check_val("br_after", 32'(reg_out), 32'd21);

    // cond 01 taken with z_flag=1
    rom_cond[6] = 2'b01; rom_jmp[6] = 16'd25; z_flag = 1'b1;
    do_reset();
    launch(16'd5); tick(); tick();
    check_val("br_z_taken", 32'(reg_out), 32'd25);

    // cond 11 follows cores_done
    rom_cond[6] = 2'b11; rom_jmp[6] = 16'd40; cores_done = 1'b1;
    do_reset();
    launch(16'd5); tick(); tick();
    check_val("br_cd_taken", 32'(reg_out), 32'd40);
    rom_jmp[6] = 16'd20; cores_done = 1'b0;
    do_reset();
    launch(16'd5); tick(); tick();
    check_val("br_cd_not", 32'(reg_out), 32'd7);

    // cond 10 not taken with z_flag=1, then stall at 7 with start ignored
    rom_cond[6] = 2'b10; rom_ops[8] = 6'h3F;
    do_reset();
    launch(16'd5); tick(); tick();
    check_val("br_z_not", 32'(reg_out), 32'd7);
    dp_stall = 1'b1; start = 1'b1; start_addr = 16'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall_pc", 32'(reg_out), 32'd7);
      check_val("stall_v", {26'd0, ops_valid, ops_out}, {26'd0, 1'b0, 6'd6});
    end
    start = 1'b0; dp_stall = 1'b0;
    tick();
    check_val("resume_pc", 32'(reg_out), 32'd8);
    check_val("resume_v", {26'd0, ops_valid, ops_out}, {26'd0, 1'b1, 6'd7});

    // HALT at 8
    tick();
    check_val("halt_flags", {28'd0, ops_valid, busy, done, err}, 32'b0010);
    check_val("halt_pc", 32'(reg_out), 32'd8);
    check_val("halt_ops", 32'(ops_out), 32'd7);
    tick();
    check_val("idle_flags", {28'd0, ops_valid, busy, done, err}, 32'b0000);
    tick();
    check_val("idle_pc", 32'(reg_out), 32'd8);

    // rerun from 10, then reset mid-run at 12 while start and stall are high
    launch(16'd10);
    check_val("rerun_pc", 32'(reg_out), 32'd10);
    tick(); tick();
    check_val("rerun_pc12", 32'(reg_out), 32'd12);
    check_val("rerun_ops", 32'(ops_out), 32'd11);
    rst_n = 1'b0; start = 1'b1; dp_stall = 1'b1; start_addr = 16'd3;
    tick();
    check_val("mid_rst_pc", 32'(reg_out), 32'd0);
    check_val("mid_rst_ops", 32'(ops_out), 32'd0);
    check_val("mid_rst_flags", {28'd0, ops_valid, busy, done, err}, 32'd0);
    rst_n = 1'b1; start = 1'b0; dp_stall = 1'b0;

    // 16-bit wrap
    launch(16'hFFFF);
    tick();
    check_val("wrap_pc", 32'(reg_out), 32'd0);

    // call/return and nested calls
    rom_clear();
    rom_bt[2] = 1'b1; rom_ops[2] = 6'h3E; rom_jmp[2] = 16'd30;
    rom_ops[30] = 6'h3D;
    for (int a = 32; a <= 36; a++) begin
      rom_bt[a] = 1'b1; rom_ops[a] = 6'h3E; rom_jmp[a] = 16'(a + 1);
    end
    do_reset();
    launch(16'd2);
    tick();
    check_val("call_pc", 32'(reg_out), 32'd30);
    check_val("call_ops", {26'd0, ops_valid, ops_out}, {26'd0, 1'b1, 6'h3E});
    tick();
`ifdef MSEQ_CALL_STACK_EN
    check_val("ret_pc", 32'(reg_out), 32'd3);
`else
    check_val("ret_pc", 32'(reg_out), 32'd31);
`endif
    check_val("ret_ops", {26'd0, ops_valid, ops_out}, {26'd0, 1'b1, 6'h3D});

    do_reset();
    launch(16'd32);
    for (int i = 0; i < 5; i++) tick();
`ifdef MSEQ_CALL_STACK_EN
    check_val("ovf_pc", 32'(reg_out), 32'd36);
    check_val("ovf_flags", {28'd0, ops_valid, busy, done, err}, 32'b0001);
    tick();
    check_val("ovf_sticky", {28'd0, ops_valid, busy, done, err}, 32'b0001);
    launch(16'd5);
    check_val("err_clear", {28'd0, ops_valid, busy, done, err}, 32'b0100);
    check_val("err_clear_pc", 32'(reg_out), 32'd5);
    rom_bt[5] = 1'b0; rom_ops[5] = 6'h3D;
    do_reset();
    launch(16'd5);
    tick();
    check_val("unf_flags", {28'd0, ops_valid, busy, done, err}, 32'b0001);
    check_val("unf_pc", 32'(reg_out), 32'd5);
`else
    check_val("nest_pc", 32'(reg_out), 32'd37);
    check_val("nest_flags", {28'd0, ops_valid, busy, done, err}, 32'b1100);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
